// File: rtl/boot_image_copier.sv
// boot_image_copier: copies the boot image from ROM into SDRAM, reads it back to verify,
// and holds the processor in reset until both passes are complete.
module boot_image_copier #(
    parameter int unsigned WORDS     = 1000,
    parameter int unsigned ROM_AW    = 10,
    parameter int unsigned MEM_AW    = 24,
    parameter int unsigned DW        = 32,
    parameter int unsigned DEST_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DW-1:0]     rom_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error,
    output logic [15:0]       err_count
);
    typedef enum logic [2:0] {
        COPY_RD, COPY_WT, COPY_WR, COPY_ACK, VER_RD, VER_ACK, FINISH
    } state_t;

    state_t            state_q;
    logic [ROM_AW-1:0] idx_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [DW-1:0]     mem_wdata_q;
    logic              cpu_rst_n_q;
    logic              done_q;
    logic              error_q;
    logic [15:0]       err_count_q;

    logic              last;
    logic [MEM_AW-1:0] dest;

    assign last = idx_q == ROM_AW'(WORDS - 1);
    assign dest = MEM_AW'(DEST_BASE) + MEM_AW'(idx_q);

    // rom_addr is advanced on each verify ack so the ROM word is already valid
    // in the first VER_ACK cycle, even when the ack arrives as the request rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COPY_RD;
            idx_q       <= '0;
            rom_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                COPY_RD: begin
                    rom_addr_q <= idx_q;
                    state_q    <= COPY_WT;
                end
                COPY_WT: state_q <= COPY_WR;
                COPY_WR: begin
                    mem_wdata_q <= rom_data;
                    mem_addr_q  <= dest;
                    mem_we_q    <= 1'b1;
                    mem_req_q   <= 1'b1;
                    state_q     <= COPY_ACK;
                end
                COPY_ACK: if (mem_ack) begin
                    mem_req_q <= 1'b0;
                    if (last) begin
                        idx_q      <= '0;
                        rom_addr_q <= '0;
                        state_q    <= VER_RD;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= COPY_RD;
                    end
                end
                VER_RD: begin
                    rom_addr_q <= idx_q;
                    mem_addr_q <= dest;
                    mem_we_q   <= 1'b0;
                    mem_req_q  <= 1'b1;
                    state_q    <= VER_ACK;
                end
                VER_ACK: if (mem_ack) begin
                    mem_req_q <= 1'b0;
                    if (mem_rdata != rom_data) begin
                        error_q <= 1'b1;
                        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 1'b1;
                    end
                    if (last) begin
                        state_q <= FINISH;
                    end else begin
                        idx_q      <= idx_q + 1'b1;
                        rom_addr_q <= idx_q + 1'b1;
                        state_q    <= VER_RD;
                    end
                end
                FINISH: begin
                    done_q      <= 1'b1;
                    cpu_rst_n_q <= 1'b1;
                end
                default: state_q <= COPY_RD;
            endcase
        end
    end

    assign rom_addr  = rom_addr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_boot_image_copier.sv
// tb_boot_image_copier: three copier instances (4 words @0, 4 words @0x100, 1 word @0xFFFFFF)
// served one at a time by a randomized-latency SDRAM model with logging and corruption.
module tb_boot_image_copier;
    localparam int NI = 3;
    localparam int WA [NI] = '{4, 4, 1};
    localparam logic [23:0] BA [NI] = '{24'h000000, 24'h000100, 24'hFFFFFF};

    typedef struct {
        int sel; int lo; int hi; int c0; int c1; bit spur; bit rnd; int exp_err; int exp_cyc;
    } scn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0]  rom_addr [NI];
    logic        req [NI], we [NI], cpu [NI], dn [NI], er [NI];
    logic [23:0] addr [NI];
    logic [31:0] wdata [NI];
    logic [15:0] ecnt [NI];
    logic [31:0] rom [1024];
    logic [31:0] rdata = '0;
    logic        ack_m = 1'b0;
    int          sel = 0;

    logic        req_m, we_m, cpu_m, done_m, err_m;
    logic [23:0] addr_m;
    logic [31:0] wdata_m;
    logic [15:0] ecnt_m;
    logic [9:0]  rom_addr_m;

    int ncmp = 0, nerr = 0;
    int lat_lo = 1, lat_hi = 1, c0 = -1, c1 = -1;
    bit spur = 0;
    bit busy = 0, fall_chk = 0, cwe = 0, cpu_bad = 0, prev_done = 0;
    logic [23:0] caddr;
    logic [31:0] cwd;
    int w = 0, drises = 0;
    logic [31:0] sdram [logic [23:0]];
    logic [23:0] wl_a [$], rl_a [$];
    logic [31:0] wl_d [$];

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [31:0] rd;
        always @(posedge clk) rd <= rom[rom_addr[g]];
        boot_image_copier #(.WORDS(WA[g]), .DEST_BASE(BA[g])) u_dut (
            .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr[g]), .rom_data(rd),
            .mem_req(req[g]), .mem_we(we[g]), .mem_addr(addr[g]), .mem_wdata(wdata[g]),
            .mem_ack(ack_m && sel == g), .mem_rdata(rdata),
            .cpu_rst_n(cpu[g]), .done(dn[g]), .error(er[g]), .err_count(ecnt[g])
        );
    end

    always_comb begin
        req_m      = req[sel];
        we_m       = we[sel];
        addr_m     = addr[sel];
        wdata_m    = wdata[sel];
        cpu_m      = cpu[sel];
        done_m     = dn[sel];
        err_m      = er[sel];
        ecnt_m     = ecnt[sel];
        rom_addr_m = rom_addr[sel];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // SDRAM model: accepts a request, waits a random number of cycles, pulses ack once.
    initial forever begin
        @(negedge clk);
        ack_m = 1'b0;
        if (done_m && !prev_done) drises++;
        prev_done = done_m;
        if (!rst_n) begin
            busy = 0;
            fall_chk = 0;
        end else begin
            if (fall_chk) begin
                chk("req_fall", req_m, 0);
                fall_chk = 0;
            end
            if (busy) begin
                chk("hold", {req_m, we_m, addr_m, wdata_m}, {1'b1, cwe, caddr, cwd});
            end else if (req_m) begin
                busy  = 1;
                cwe   = we_m;
                caddr = addr_m;
                cwd   = wdata_m;
                w     = $urandom_range(lat_hi, lat_lo);
            end
            if (busy) begin
                if (w == 0) begin
                    ack_m = 1'b1;
                    busy = 0;
                    fall_chk = 1;
                    if (cwe) begin
                        sdram[caddr] = cwd;
                        wl_a.push_back(caddr);
                        wl_d.push_back(cwd);
                    end else begin
                        rdata = sdram.exists(caddr) ? sdram[caddr] : 32'h0;
                        if (int'(caddr) == c0 || int'(caddr) == c1) rdata = rdata ^ 32'h1;
                        rl_a.push_back(caddr);
                    end
                end else begin
                    w--;
                end
            end else if (spur && !req_m && $urandom_range(1, 0) == 1) begin
                ack_m = 1'b1;
            end
        end
    end

    task automatic clear_logs();
        wl_a.delete();
        wl_d.delete();
        rl_a.delete();
        sdram.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_done"}, done_m, 0);
        chk({tag, "_cpu_rst_n"}, cpu_m, 0);
        chk({tag, "_error"}, err_m, 0);
        chk({tag, "_err_count"}, ecnt_m, 0);
        chk({tag, "_mem_bus"}, {req_m, we_m, addr_m, wdata_m}, 0);
        chk({tag, "_rom_addr"}, rom_addr_m, 0);
    endtask

    task automatic start(input int s, input int lo, input int hi, input int a, input int b,
                         input bit sp, input bit rr);
        rst_n = 1'b0;
        sel = s; lat_lo = lo; lat_hi = hi; c0 = a; c1 = b; spur = sp;
        rom[0] = 32'hDEADBEEF; rom[1] = 32'h00000001; rom[2] = 32'hCAFEF00D; rom[3] = 32'hFFFFFFFF;
        if (rr) for (int i = 0; i < 4; i++) rom[i] = $urandom;
        clear_logs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drises = 0;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        cpu_bad = 0;
        while (!done_m && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (cpu_m !== done_m) cpu_bad = 1;
        end
        if (!done_m) chk("done_timeout", done_m, 1);
    endtask

    task automatic check_results(input int s, input int exp_err, input int exp_cyc, input int cyc);
        if (exp_cyc >= 0) chk("latency", cyc, exp_cyc);
        chk("done", done_m, 1);
        chk("cpu_rst_n", cpu_m, 1);
        chk("cpu_rst_n_vs_done", cpu_bad, 0);
        chk("error", err_m, exp_err != 0);
        chk("err_count", ecnt_m, exp_err);
        chk("n_writes", wl_a.size(), WA[s]);
        chk("n_reads", rl_a.size(), WA[s]);
        for (int i = 0; i < WA[s]; i++) begin
            logic [23:0] ea;
            ea = BA[s] + 24'(i);
            if (i < wl_a.size()) begin
                chk("wr_addr", wl_a[i], ea);
                chk("wr_data", wl_d[i], rom[i]);
            end
            if (i < rl_a.size()) chk("rd_addr", rl_a[i], ea);
        end
        repeat (10) @(negedge clk);
        chk("done_once", drises, 1);
        chk("done_sticky", done_m, 1);
    endtask

    initial begin
        scn_t t [7];
        int cyc;
        t[0] = '{0, 1, 1, -1, -1, 1'b0, 1'b0, 0, 33};
        t[1] = '{1, 1, 20, -1, -1, 1'b0, 1'b0, 0, -1};
        t[2] = '{0, 1, 1, 1, 3, 1'b0, 1'b0, 2, 33};
        t[3] = '{2, 1, 1, -1, -1, 1'b0, 1'b0, 0, 9};
        t[4] = '{1, 0, 5, 32'h101, -1, 1'b1, 1'b1, 1, -1};
        t[5] = '{2, 0, 3, 32'hFFFFFF, -1, 1'b1, 1'b1, 1, -1};
        t[6] = '{0, 0, 20, -1, -1, 1'b1, 1'b1, 0, -1};

        repeat (2) @(negedge clk);
        chk_reset("reset");

        for (int i = 0; i < 7; i++) begin
            start(t[i].sel, t[i].lo, t[i].hi, t[i].c0, t[i].c1, t[i].spur, t[i].rnd);
            wait_done(20000, cyc);
            check_results(t[i].sel, t[i].exp_err, t[i].exp_cyc, cyc);
        end

        // reset pulse while the third copy write is outstanding
        start(0, 2, 4, -1, -1, 1'b0, 1'b1);
        cyc = 0;
        while (!(wl_a.size() == 2 && busy && cwe) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("third_write_seen", wl_a.size(), 2);
        #2 rst_n = 1'b0;
        #1 chk_reset("async");
        @(negedge clk);
        clear_logs();
        #2 rst_n = 1'b1;
        drises = 0;
        wait_done(20000, cyc);
        check_results(0, 0, -1, cyc);

        // long stall on every transaction, spurious acks in the idle gaps
        start(0, 1000, 1000, -1, -1, 1'b1, 1'b0);
        repeat (600) @(negedge clk);
        chk("stall_no_write", wl_a.size(), 0);
        chk("stall_req_held", req_m, 1);
        chk("stall_not_done", done_m, 0);
        wait_done(20000, cyc);
        check_results(0, 0, -1, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/boot_image_copier.md
Name: boot_image_copier

Overview:
- Sits between the on-chip bootloader ROM and the SDRAM controller, upstream of the processor.
- After reset it copies WORDS words from the ROM into SDRAM starting at DEST_BASE.
- It then reads every word back and compares it against the ROM.
- It holds the processor in reset until the copy and verify pass completes.

Parameters:
- WORDS, 1000, number of 32-bit words to copy (1..2**ROM_AW).
- ROM_AW, 10, ROM word-address width.
- MEM_AW, 24, SDRAM controller word-address width.
- DW, 32, data width.
- DEST_BASE, 0, first SDRAM word address written.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  ROM_AW  ROM word address.
- rom_data  in  DW  ROM read data, valid exactly 1 cycle after rom_addr is presented.
- mem_req  out  1  SDRAM transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  MEM_AW  SDRAM word address.
- mem_wdata  out  DW  write data.
- mem_ack  in  1  1-cycle pulse; the transaction is complete and mem_rdata is valid for reads.
- mem_rdata  in  DW  read data.
- cpu_rst_n  out  1  processor reset, low until done.
- done  out  1  copy and verify finished (sticky).
- error  out  1  at least one verify mismatch (sticky).
- err_count  out  16  number of mismatches, saturating at 16'hFFFF.

Behaviour:
- Reset values (asynchronous):
  - state = COPY_RD.
  - idx = 0.
  - rom_addr = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_rst_n = 0, done = 0, error = 0, err_count = 0.
- States and transitions:
  - COPY_RD: rom_addr <= idx; go to COPY_WT.
  - COPY_WT: one-cycle ROM latency; go to COPY_WR.
  - COPY_WR: latch mem_wdata <= rom_data, mem_addr <= DEST_BASE + idx, mem_we <= 1, mem_req <= 1; go to COPY_ACK.
  - COPY_ACK: hold all mem_* stable until mem_ack.
    - On mem_ack: mem_req <= 0 the next edge.
    - If idx == WORDS-1: idx <= 0, go to VER_RD.
    - Else: idx <= idx + 1, go to COPY_RD.
  - VER_RD: rom_addr <= idx, mem_addr <= DEST_BASE + idx, mem_we <= 0, mem_req <= 1; go to VER_ACK.
  - VER_ACK: hold the request until mem_ack.
    - On mem_ack: compare mem_rdata with rom_data. rom_data is stable because rom_addr was unchanged for at least 1 cycle.
    - On mismatch: error <= 1 and err_count++ (saturating).
    - If idx == WORDS-1: go to FINISH.
    - Else: idx <= idx + 1, go to VER_RD.
  - FINISH: done <= 1, cpu_rst_n <= 1; stay in FINISH until reset.
- Handshake:
  - mem_req rises only in COPY_WR or VER_RD.
  - mem_req, mem_we, mem_addr and mem_wdata must not change while mem_req = 1 and no ack has been seen.
  - mem_req falls on the edge after the mem_ack cycle.
  - At least 1 idle cycle separates consecutive requests.
  - A mem_ack arriving while mem_req = 0 is ignored.
  - A mem_ack in the same cycle that mem_req first rises counts as a valid ack.
- Address arithmetic:
  - DEST_BASE + idx is computed modulo 2**MEM_AW; a wrap past the top is silently allowed.
  - idx is ROM_AW bits wide and never exceeds WORDS-1.
- Boundary cases:
  - WORDS = 1: exactly one write followed by one read.
  - A stalled mem_ack (never returns) keeps the block waiting indefinitely; there is no timeout.
  - cpu_rst_n never pulses high before FINISH.
  - Reset asserted mid-copy or mid-verify returns every output to its reset value immediately. The full copy restarts from idx 0 after rst_n deasserts, and error/err_count are cleared.
  - done and error are independent: done = 1 even when error = 1. cpu_rst_n is released regardless of error; software checks the error flag via the status path.
- Latency with a zero-wait controller (ack 1 cycle after the request rises):
  - Copy: 5 cycles/word. Verify: 3 cycles/word. FINISH is reached 8*WORDS + 1 cycles after rst_n rises.

Test Plan:
- WORDS=4, ROM = {32'hDEADBEEF, 32'h00000001, 32'hCAFEF00D, 32'hFFFFFFFF}, ideal memory model with ack latency 1 → 4 writes to addresses 0..3 with matching data, then 4 reads; done = 1, error = 0, err_count = 0; cpu_rst_n rises in the same cycle as done.
- Memory model with random ack latency 1..20 and DEST_BASE = 24'h000100 → mem_* outputs stable for the whole of every request; writes land at 0x100..0x103; done = 1, error = 0.
- Memory model corrupts read data at addresses 1 and 3 (XOR 1) → error = 1, err_count = 2, done = 1, cpu_rst_n = 1.
- rst_n pulsed low for 1 cycle during the 3rd copy write → all outputs return to reset values asynchronously; the restart rewrites from address 0, the sequence completes, and exactly one final done occurs.
- WORDS=1 and DEST_BASE = 24'hFFFFFF → single write then single read at 24'hFFFFFF; done = 1.
- Ack held off for 1000 cycles, plus a spurious mem_ack while mem_req = 0 → block waits without advancing and ignores the spurious ack; the word count written equals WORDS.
